// File: rtl/core_pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline registers: occupancy
// state encoding and the payload width of each stage boundary.
package core_pipe_pkg;

  // Number of beats held by a pipeline-stage register.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Payload widths of each stage boundary.
  localparam int IF_ID_W  = 64;   // PCPlus4 + Instr
  localparam int ID_EX_W  = 160;  // PC, rs1/rs2 data, imm, rd + control
  localparam int EX_MEM_W = 112;  // ALU result, store data, rd + control
  localparam int MEM_WB_W = 72;   // writeback value, rd + control

  typedef enum logic [1:0] {
    BND_IF_ID,
    BND_ID_EX,
    BND_EX_MEM,
    BND_MEM_WB
  } boundary_e;

  // Payload width for a given stage boundary, used by stage wrappers.
  function automatic int boundary_width(input boundary_e b);
    case (b)
      BND_IF_ID:  return IF_ID_W;
      BND_ID_EX:  return ID_EX_W;
      BND_EX_MEM: return EX_MEM_W;
      default:    return MEM_WB_W;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake,
// hazard hold/flush, and an optional 2-entry skid buffer.
//
// Handshake: a beat moves upstream->stage when in_valid & in_ready at a
// rising edge, and stage->downstream when out_valid & out_ready & ~hold.
// in_valid/in_data must stay stable until accepted; out_valid/out_data stay
// stable until emitted (or flushed). While out_valid=0, out_data = BUBBLE.
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int               WIDTH  = IF_ID_W,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit               SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Entry A always drives out_data; entry B is the skid slot (SKID=1 only).
  occ_e             state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             accept;
  logic             emit;

  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = a_q;
  assign occupancy = state_q;

  // Handshake qualifiers; with SKID=1 in_ready depends only on state.
  always_comb begin
    emit = out_valid & out_ready & ~hold;
    if (SKID) begin
      in_ready = (state_q != OCC_FULL);
    end else begin
      in_ready = (state_q == OCC_EMPTY) | emit;
    end
    accept = in_valid & in_ready;
  end

  // Next-state and entry update; flush overrides everything below reset.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d = OCC_ONE;
          a_d     = in_data;
        end
      end
      OCC_ONE: begin
        if (accept && emit) begin
          a_d = in_data;
        end else if (accept && SKID) begin
          state_d = OCC_FULL;
          b_d     = in_data;
        end else if (emit) begin
          state_d = OCC_EMPTY;
          a_d     = BUBBLE;
        end
      end
      OCC_FULL: begin
        if (emit) begin
          state_d = OCC_ONE;
          a_d     = b_q;
          b_d     = BUBBLE;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
        a_d     = BUBBLE;
        b_d     = BUBBLE;
      end
    endcase
    if (flush) begin
      state_d = OCC_EMPTY;
      a_d     = BUBBLE;
      b_d     = BUBBLE;
    end
  end

  // State and entry registers with synchronous reset to the empty bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      a_q     <= BUBBLE;
      b_q     <= BUBBLE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, directed
// scenarios followed by random traffic, with a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int          W      = 64;
  localparam logic [W-1:0] BUBBLE = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // SKID=1 instance signals
  logic         s_flush = 0, s_hold = 0, s_in_valid = 0, s_out_ready = 0;
  logic [W-1:0] s_in_data = '0;
  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occupancy;

  // SKID=0 instance signals
  logic         n_flush = 0, n_hold = 0, n_in_valid = 0, n_out_ready = 0;
  logic [W-1:0] n_in_data = '0;
  logic         n_in_ready, n_out_valid;
  logic [W-1:0] n_out_data;
  logic [1:0]   n_occupancy;

  logic [W-1:0] s_q[$];
  logic [W-1:0] n_q[$];

  // Clock and overall time bound
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUBBLE), .SKID(1'b1)) dut_s (
    .clk(clk), .rst(rst), .flush(s_flush), .hold(s_hold),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy)
  );

  pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUBBLE), .SKID(1'b0)) dut_n (
    .clk(clk), .rst(rst), .flush(n_flush), .hold(n_hold),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the SKID=1 instance; the queue holds beats in flight.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_rdy, exp_emit;
      int   sz;
      sz       = s_q.size();
      exp_rdy  = (sz != 2);
      exp_emit = (sz != 0) && s_out_ready && !s_hold;
      check("s_occupancy", W'(s_occupancy), W'(sz));
      check("s_out_valid", W'(s_out_valid), W'(sz != 0));
      check("s_out_data", s_out_data, (sz != 0) ? s_q[0] : BUBBLE);
      check("s_in_ready", W'(s_in_ready), W'(exp_rdy));
      if (s_flush) begin
        s_q.delete();
      end else begin
        if (exp_emit) void'(s_q.pop_front());
        if (s_in_valid && exp_rdy) s_q.push_back(s_in_data);
      end
    end else begin
      s_q.delete();
    end
  end

  // Scoreboard for the SKID=0 instance.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_rdy, exp_emit;
      int   sz;
      sz       = n_q.size();
      exp_emit = (sz != 0) && n_out_ready && !n_hold;
      exp_rdy  = (sz == 0) || exp_emit;
      check("n_occupancy", W'(n_occupancy), W'(sz));
      check("n_out_valid", W'(n_out_valid), W'(sz != 0));
      check("n_out_data", n_out_data, (sz != 0) ? n_q[0] : BUBBLE);
      check("n_in_ready", W'(n_in_ready), W'(exp_rdy));
      if (n_flush) begin
        n_q.delete();
      end else begin
        if (exp_emit) void'(n_q.pop_front());
        if (n_in_valid && exp_rdy) n_q.push_back(n_in_data);
      end
    end else begin
      n_q.delete();
    end
  end

  initial begin
    // Reset with a beat presented upstream
    rst = 1; s_in_valid = 1; s_in_data = 64'hA;
    step(); step();
    rst = 0; s_in_valid = 0;
    check("rst_out_valid", W'(s_out_valid), 0);
    check("rst_out_data", s_out_data, BUBBLE);
    check("rst_occupancy", W'(s_occupancy), 0);
    check("rst_in_ready", W'(s_in_ready), 1);
    step();

    // Streaming at full throughput
    s_out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      s_in_valid = 1; s_in_data = W'(i);
      step();
      check("stream_data", s_out_data, W'(i));
      check("stream_occ", W'(s_occupancy), 1);
    end
    s_in_valid = 0;
    step();
    check("stream_drain", W'(s_out_valid), 0);

    // Backpressure into the skid entry
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'd5; step();
    s_in_data = 64'd6; step();
    check("skid_occ_full", W'(s_occupancy), 2);
    check("skid_in_ready", W'(s_in_ready), 0);
    s_in_data = 64'd7; step();
    check("skid_occ_held", W'(s_occupancy), 2);
    check("skid_head", s_out_data, 64'd5);
    s_out_ready = 1; step();
    check("skid_out6", s_out_data, 64'd6);
    step();
    check("skid_out7", s_out_data, 64'd7);
    s_in_valid = 0; step();
    check("skid_empty", W'(s_occupancy), 0);

    // Hold freezes the beat even though downstream is ready
    s_hold = 1; s_in_valid = 1; s_in_data = 64'h42; step();
    s_in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_data", s_out_data, 64'h42);
      check("hold_valid", W'(s_out_valid), 1);
    end
    s_hold = 0; step();
    check("hold_release", W'(s_out_valid), 0);

    // Flush while full with a beat arriving
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'd9; step();
    s_in_data = 64'd10; step();
    check("flush_pre_occ", W'(s_occupancy), 2);
    s_in_data = 64'd11; s_flush = 1; s_hold = 1; step();
    s_flush = 0; s_hold = 0; s_in_valid = 0;
    check("flush_valid", W'(s_out_valid), 0);
    check("flush_data", s_out_data, BUBBLE);
    check("flush_occ", W'(s_occupancy), 0);
    s_out_ready = 1; step();
    check("flush_dropped", W'(s_occupancy), 0);

    // Random traffic on the skid instance
    for (int i = 0; i < 300; i++) begin
      s_in_valid  = 1'($urandom_range(0, 1));
      s_in_data   = {$urandom, $urandom};
      s_out_ready = ($urandom_range(0, 3) != 0);
      s_hold      = ($urandom_range(0, 7) == 0);
      s_flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    s_in_valid = 0; s_flush = 0; s_hold = 0; s_out_ready = 1;
    step(); step(); step();

    // SKID=0: combinational in_ready while streaming
    n_out_ready = 1;
    for (int i = 20; i <= 25; i++) begin
      n_in_valid = 1; n_in_data = W'(i);
      step();
      check("n_stream_ready", W'(n_in_ready), 1);
      check("n_stream_data", n_out_data, W'(i));
    end
    n_out_ready = 0; n_in_data = 64'd26;
    #1;
    check("n_ready_drop", W'(n_in_ready), 0);
    step();
    check("n_blocked_data", n_out_data, 64'd25);
    check("n_blocked_occ", W'(n_occupancy), 1);
    n_out_ready = 1;
    #1;
    check("n_ready_rise", W'(n_in_ready), 1);
    step();
    check("n_next_data", n_out_data, 64'd26);
    n_in_valid = 0; step();
    check("n_drain", W'(n_out_valid), 0);

    // Random traffic on the single-entry instance
    for (int i = 0; i < 300; i++) begin
      n_in_valid  = 1'($urandom_range(0, 1));
      n_in_data   = {$urandom, $urandom};
      n_out_ready = ($urandom_range(0, 3) != 0);
      n_hold      = ($urandom_range(0, 7) == 0);
      n_flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    n_in_valid = 0; n_flush = 0; n_hold = 0; n_out_ready = 1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
